aes_key_sched_ctrl: RTL

Sequencing controller directly upstream of the 128-bit iterative AES key scheduler. It drives the scheduler's 2-bit control_signal (hold/load/forward/reverse) and 4-bit round_number, and hands round keys to the round datapath under a valid/advance handshake. Encrypt mode walks keys 0→10 forward. Decrypt mode first warms up forward to key 10, then walks 10→0 in reverse.

---
 rtl/aes_ks_ctrl_pkg.sv | 22 ++
 rtl/aes_key_sched_ctrl.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/aes_ks_ctrl_pkg.sv
// Shared encodings for the AES-128 key-schedule sequencing controller.
// Control codes match the iterative scheduler's control_signal input.
package aes_ks_ctrl_pkg;

  localparam int NR    = 10;
  localparam int IDX_W = 4;

  localparam logic [IDX_W-1:0] NR_IDX = IDX_W'(NR);

  localparam logic [1:0] KS_HOLD = 2'b00;
  localparam logic [1:0] KS_LOAD = 2'b01;
  localparam logic [1:0] KS_FWD  = 2'b10;
  localparam logic [1:0] KS_REV  = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WARM   = 2'd1,
    SERVE  = 2'd2,
    REWIND = 2'd3
  } state_e;

endpackage

// File: rtl/aes_key_sched_ctrl.sv
// Sequences the iterative AES-128 key scheduler: load, forward warm-up, serve keys fwd/rev.
// Optional AES_KEY_REUSE_EN adds restart of the key already held in the scheduler.
module aes_key_sched_ctrl
  import aes_ks_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_valid,
  input  logic             mode,
  input  logic             key_adv,
  input  logic             abort,
`ifdef AES_KEY_REUSE_EN
  input  logic             restart,
  input  logic             restart_mode,
`endif
  output logic             key_ready,
  output logic [1:0]       control_signal,
  output logic [IDX_W-1:0] round_number,
  output logic             key_vld,
  output logic [IDX_W-1:0] key_idx,
  output logic             last_key,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] cur_idx_q, cur_idx_d;
  logic             mode_q, mode_d;
`ifdef AES_KEY_REUSE_EN
  logic             loaded_q, loaded_d;
`endif

  logic [IDX_W-1:0] idx_inc;
  logic [IDX_W-1:0] idx_dec;

  assign idx_inc = cur_idx_q + IDX_W'(1);
  assign idx_dec = cur_idx_q - IDX_W'(1);

  assign key_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign key_vld   = (state_q == SERVE);
  assign key_idx   = cur_idx_q;
  // Final key is NR going forward, 0 going backward.
  assign last_key  = key_vld && (mode_q ? (cur_idx_q == '0) : (cur_idx_q == NR_IDX));

  always_comb begin
    state_d        = state_q;
    cur_idx_d      = cur_idx_q;
    mode_d         = mode_q;
    control_signal = KS_HOLD;
    round_number   = cur_idx_q;
`ifdef AES_KEY_REUSE_EN
    loaded_d       = loaded_q;
`endif

    case (state_q)
      IDLE: begin
        round_number = '0;
        if (key_valid) begin
          control_signal = KS_LOAD;
          cur_idx_d      = '0;
          mode_d         = mode;
          state_d        = mode ? WARM : SERVE;
        end
`ifdef AES_KEY_REUSE_EN
        // Reuse the retained key: it sits at index 0 or NR after a completed pass.
        else if (restart && loaded_q) begin
          mode_d = restart_mode;
          if (restart_mode) begin
            state_d = (cur_idx_q == NR_IDX) ? SERVE : WARM;
          end else begin
            state_d = (cur_idx_q == '0) ? SERVE : REWIND;
          end
        end
`endif
      end

      WARM: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          control_signal = KS_FWD;
          round_number   = idx_inc;
          cur_idx_d      = idx_inc;
          if (idx_inc == NR_IDX) begin
            state_d = SERVE;
          end
        end
      end

      SERVE: begin
        if (abort) begin
          state_d = IDLE;
        end else if (key_adv) begin
          if (last_key) begin
            state_d = IDLE;
`ifdef AES_KEY_REUSE_EN
            loaded_d = 1'b1;
`endif
          end else if (!mode_q) begin
            control_signal = KS_FWD;
            round_number   = idx_inc;
            cur_idx_d      = idx_inc;
          end else begin
            control_signal = KS_REV;
            round_number   = cur_idx_q;
            cur_idx_d      = idx_dec;
          end
        end
      end

`ifdef AES_KEY_REUSE_EN
      REWIND: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          control_signal = KS_REV;
          round_number   = cur_idx_q;
          cur_idx_d      = idx_dec;
          if (cur_idx_q == IDX_W'(1)) begin
            state_d = SERVE;
          end
        end
      end
`endif

      default: begin
        state_d = IDLE;
      end
    endcase

`ifdef AES_KEY_REUSE_EN
    if (abort && (state_q != IDLE)) begin
      loaded_d = 1'b0;
    end
`endif

    // Keep the scheduler idle while this block is held in reset.
    if (!rst_n) begin
      control_signal = KS_HOLD;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cur_idx_q <= '0;
      mode_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_idx_q <= cur_idx_d;
      mode_q    <= mode_d;
    end
  end

`ifdef AES_KEY_REUSE_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      loaded_q <= 1'b0;
    end else begin
      loaded_q <= loaded_d;
    end
  end
`endif

endmodule
